// File: rtl/leb128_encoder_if.sv
// Handshake bundle for the LEB128 encoder: one operand stream in, one byte stream out.
// With LEB128_ENCODER_PAD_EN defined the bundle also carries the per-operand pad request.
interface leb128_encoder_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_value;
    logic             in_signed;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [3:0]       out_index;
`ifdef LEB128_ENCODER_PAD_EN
    logic             pad;

    // Producer of operands and consumer of bytes
    modport master (
        output in_value, in_signed, in_valid, out_ready, pad,
        input  in_ready, out_byte, out_valid, out_last, out_index
    );

    // The encoder itself
    modport slave (
        input  in_value, in_signed, in_valid, out_ready, pad,
        output in_ready, out_byte, out_valid, out_last, out_index
    );
`else
    // Producer of operands and consumer of bytes
    modport master (
        output in_value, in_signed, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last, out_index
    );

    // The encoder itself
    modport slave (
        input  in_value, in_signed, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last, out_index
    );
`endif
endinterface

// File: rtl/leb128_encoder.sv
// LEB128 encoder: turns one WIDTH-bit operand (signed or unsigned) into a stream of
// 7-bit groups, least significant first, one byte per accepted output beat.
// Optional feature macro: LEB128_ENCODER_PAD_EN adds a pad input that forces every
// value out as exactly MAXBYTES bytes (fixed-width relocatable immediates).
module leb128_encoder #(
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    leb128_encoder_if.slave bus
);

    // Longest possible encoding for this operand width (10 for 64, 5 for 32)
    localparam int         MAXBYTES   = (WIDTH + 6) / 7;
    localparam logic [3:0] LAST_INDEX = 4'(MAXBYTES - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             signed_q, signed_d;
    logic [3:0]       index_q, index_d;
`ifdef LEB128_ENCODER_PAD_EN
    logic             pad_q, pad_d;
`endif

    logic signed [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0]        rem_arith;
    logic [WIDTH-1:0]        rem_logic;
    logic [WIDTH-1:0]        rem;
    logic                    last_min;
    logic                    at_end;
    logic                    last;

    // Remainder after peeling off the current 7-bit group and the termination decision
    always_comb begin
        shift_s   = shift_q;
        rem_arith = shift_s >>> 7;
        rem_logic = shift_q >> 7;
        rem       = signed_q ? rem_arith : rem_logic;
        if (signed_q) begin
            last_min = ((rem == '0) && !shift_q[6]) || ((rem == '1) && shift_q[6]);
        end else begin
            last_min = (rem == '0);
        end
        // The minimal rule never runs past the final slot for a WIDTH-bit value;
        // stopping there as well keeps the byte count bounded by construction.
        at_end = (index_q == LAST_INDEX);
`ifdef LEB128_ENCODER_PAD_EN
        last = at_end || (!pad_q && last_min);
`else
        last = at_end || last_min;
`endif
    end

    // Next-state and output decode for the IDLE/EMIT controller
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        signed_d = signed_q;
        index_d  = index_q;
`ifdef LEB128_ENCODER_PAD_EN
        pad_d    = pad_q;
`endif
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_byte  = 8'h00;
        bus.out_last  = 1'b0;
        bus.out_index = 4'd0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift_d  = bus.in_value;
                    signed_d = bus.in_signed;
                    index_d  = 4'd0;
`ifdef LEB128_ENCODER_PAD_EN
                    pad_d    = bus.pad;
`endif
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = {~last, shift_q[6:0]};
                bus.out_last  = last;
                bus.out_index = index_q;
                if (bus.out_ready) begin
                    shift_d = rem;
                    index_d = index_q + 4'd1;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and byte counter; reset abandons any value in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            signed_q <= 1'b0;
            index_q  <= 4'd0;
`ifdef LEB128_ENCODER_PAD_EN
            pad_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            signed_q <= signed_d;
            index_q  <= index_d;
`ifdef LEB128_ENCODER_PAD_EN
            pad_q    <= pad_d;
`endif
        end
    end

endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
- Serialises integer operands into LEB128 byte streams, the same encoding the cpu's bytecode decoder consumes for immediates.
- Forms the writer end of the immediate path and is used by the bytecode assembler/loader logic that fills the ROM image.
- Accepts one value per transaction over a valid/ready handshake and emits bytes one per accepted beat.
- Supports both unsigned (u32/u64) and signed (i32/i64) encodings.

Parameters:
- WIDTH, 64, operand width in bits; supported values 32 and 64.
- MAXBYTES, (WIDTH+6)/7, maximum encoded length (10 for 64, 5 for 32); derived, not overridden.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_value  input  WIDTH  operand to encode
- in_signed  input  1  1 = signed LEB128, 0 = unsigned
- in_valid  input  1  operand present
- in_ready  output  1  encoder idle; operand accepted when in_valid && in_ready
- out_byte  output  8  encoded byte: bit7 = continuation flag, bits6:0 = payload
- out_valid  output  1  out_byte valid
- out_ready  input  1  sink accepts byte
- out_last  output  1  current byte is final (bit7 of out_byte is 0)
- out_index  output  4  index of current byte within the value, starting at 0

Behaviour:
- Reset (async, any state) forces IDLE, clears the shift register, and discards any in-flight encoding:
  - in_ready=1
  - out_valid=0
  - out_byte=0x00
  - out_last=0
  - out_index=0
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1 and out_valid=0; out_byte, out_last and out_index are held at 0.
  - On in_valid, latch in_value into the WIDTH-bit shift register and latch in_signed, clear out_index, and go to EMIT.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_byte is combinational from the register: payload = reg[6:0].
  - Let rem = reg >> 7, using an arithmetic shift when signed and a logical shift when unsigned.
  - Unsigned: last when rem == 0.
  - Signed: last when (rem == 0 && reg[6] == 0) || (rem == all-ones && reg[6] == 1).
  - out_byte[7] = ~last; out_last = last.
- Beat (out_valid && out_ready):
  - reg <= rem; out_index <= out_index + 1.
  - If last, go to IDLE.
- No beat (out_ready=0): out_byte, out_last and out_index are held stable; the sink may stall indefinitely.
- Latency and throughput:
  - The first byte is valid on the cycle after acceptance.
  - A value of N bytes occupies N beat cycles.
  - The next operand can be accepted on the cycle after the last beat, so there is a one-cycle bubble between values.
- Length: out_index never exceeds MAXBYTES-1; the termination rule guarantees this for any WIDTH-bit value.
- Input changes while in EMIT are ignored.

Optional Feature:
- Macro: LEB128_ENCODER_PAD_EN.
- Defined:
  - Adds input port pad (1 bit), latched with the operand.
  - When pad=1, every value is emitted as exactly MAXBYTES bytes.
  - Bytes before index MAXBYTES-1 carry bit7=1, including redundant sign-fill bytes: 0x80 for non-negative values, 0xFF for negative signed values.
  - Byte MAXBYTES-1 has bit7=0.
  - Payloads remain the successive 7-bit groups of the (sign-extended) value.
  - This supports fixed-width relocatable immediates.
  - When pad=0, behaviour is identical to the undefined case.
- Undefined: the pad port is absent and the minimal encoding is always emitted.

Test Plan:
- Reset, then unsigned 0 with out_ready=1 -> single byte 0x00, out_last=1, out_index=0; in_ready back to 1 the following cycle.
- Unsigned 624485 -> bytes 0xE5, 0x8E, 0x26; out_last only on 0x26; out_index 0,1,2.
- Signed -123456 -> 0xC0, 0xBB, 0x78; signed -1 -> 0x7F; signed 64 -> 0xC0, 0x00; signed 63 -> 0x3F.
- Unsigned 0xFFFFFFFFFFFFFFFF (WIDTH=64) -> nine 0xFF bytes then 0x01, out_index reaching 9.
- Backpressure: unsigned 300 with out_ready low for 3 cycles after the first byte -> 0xAC held stable with out_index=0, then 0xAC, 0x02 delivered. Assert reset between the two bytes -> out_valid=0 immediately, in_ready=1, and no further bytes are emitted.
- With LEB128_ENCODER_PAD_EN:
  - unsigned 3, pad=1 -> 0x83, eight 0x80, then 0x00 (10 bytes).
  - signed -2, pad=1 -> 0xFE, eight 0xFF, then 0x7F.
